// File: rtl/cpu_trace_pkg.sv
// Shared types and sizing helpers for the CPU trace capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_trace_pkg;

  // Capture FSM, 3-bit encoding with fixed values so debug readback is stable.
  typedef enum logic [2:0] {
    TR_IDLE  = 3'd0,
    TR_ARMED = 3'd1,
    TR_POST  = 3'd2,
    TR_DONE  = 3'd3,
    TR_READ  = 3'd4
  } state_t;

  // Pointer width for a power-of-two buffer depth (PTR_W).
  function automatic int tr_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Width of one captured entry, all channels side by side (ENTRY_W).
  function automatic int tr_entry_w(input int nch, input int width);
    return nch * width;
  endfunction

endpackage

// File: rtl/cpu_trace_buffer_ram.sv
// trace_ram: DEPTH x ENTRY_W register array, one sync write port, one async read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; writes are accepted every cycle we is high.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read).
module trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 128,
  parameter int PTR_W   = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [PTR_W-1:0]   waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [PTR_W-1:0]   raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Contents are not reset; the control logic never reads an unwritten slot.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: pc-triggered logic analyser, circular capture of NCH x WIDTH channels.
// Latency: DONE exactly POST qualified samples after the trigger sample; first rd_valid 1 cycle after DONE.
// Backpressure: readout is valid/ready, 1 entry/cycle; rd_data holds while rd_valid && !rd_ready.
// Ports: clk/clr (sync active-high reset), arm, trig_en/trig_pc (trigger), sample_en/ch_data (capture),
//        rd_valid/rd_ready/rd_data/rd_last (readout), busy/done/fill (status).
module cpu_trace_buffer
  import cpu_trace_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int POST  = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [WIDTH-1:0]       trig_pc,
  input  logic                   sample_en,
  input  logic [NCH*WIDTH-1:0]   ch_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [NCH*WIDTH-1:0]   rd_data,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int PTR_W   = tr_ptr_w(DEPTH);
  localparam int ENTRY_W = tr_entry_w(NCH, WIDTH);

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   post_cnt;
  logic [PTR_W:0]     fill_q;
  logic [PTR_W:0]     rd_cnt;     // entries still to be read out
  logic [PTR_W:0]     fill_inc;
  logic [ENTRY_W-1:0] ram_rdata;
  logic               capturing;
  logic               we;
  logic               hit;
  logic               xfer;
  logic               restart;

  assign capturing = (state == TR_ARMED) || (state == TR_POST);
  assign we        = capturing && sample_en;
  assign hit       = trig_en && (ch_data[WIDTH-1:0] == trig_pc);
  assign xfer      = rd_valid && rd_ready;
  // arm is honoured from IDLE, and also abandons a finished capture / readout.
  assign restart   = arm && ((state == TR_IDLE) || (state == TR_DONE) || (state == TR_READ));
  // Once full, the count stays at DEPTH while the oldest entry is overwritten.
  assign fill_inc  = (fill_q == (PTR_W+1)'(DEPTH)) ? fill_q : fill_q + 1'b1;

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= TR_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_q   <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + 1'b1;
        fill_q <= fill_inc;
      end
      if (restart) begin
        state  <= TR_ARMED;
        wr_ptr <= '0;
        fill_q <= '0;
      end else begin
        case (state)
          TR_ARMED: begin
            if (sample_en && hit) begin
              post_cnt <= PTR_W'(POST);
              state    <= (POST == 0) ? TR_DONE : TR_POST;
            end
          end
          TR_POST: begin
            // Later pc matches are deliberately not looked at here.
            if (sample_en) begin
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == PTR_W'(1)) state <= TR_DONE;
            end
          end
          TR_DONE: begin
            // Oldest entry: with a full buffer this is wr_ptr itself.
            rd_ptr <= wr_ptr - fill_q[PTR_W-1:0];
            rd_cnt <= fill_q;
            state  <= TR_READ;
          end
          TR_READ: begin
            if (xfer) begin
              rd_ptr <= rd_ptr + 1'b1;
              rd_cnt <= rd_cnt - 1'b1;
              if (rd_last) state <= TR_IDLE;
            end
          end
          TR_IDLE: ;
          default: state <= TR_IDLE;
        endcase
      end
    end
  end

  trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .PTR_W   (PTR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (ch_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  assign rd_valid = (state == TR_READ);
  assign rd_last  = rd_valid && (rd_cnt == (PTR_W+1)'(1));
  // Gate the data so the port reads as zero outside a readout.
  assign rd_data  = rd_valid ? ram_rdata : '0;
  assign busy     = capturing;
  assign done     = (state == TR_DONE) || (state == TR_READ);
  assign fill     = fill_q;

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Parametrised on-chip trace capture for the mini-CPU. It replaces passive waveform watching of pc/inst/aluout/memout with a synthesizable logic-analyser block.
- Samples NCH channels of WIDTH bits into a circular buffer of DEPTH entries. It triggers when channel 0 (pc) matches a programmed address, keeps POST samples after the trigger, then freezes.
- Captured entries are read out oldest-first over a valid/ready port.
- Sits beside the CPU core, fed by its debug outputs. It has no effect on CPU execution.

Parameters:
- WIDTH, 32, bits per channel.
- NCH, 4, channel count; ch 0 is the trigger-compare channel (pc); defaults map to pc, inst, aluout, memout.
- DEPTH, 16, buffer entries; power of two, >= 4.
- POST, 8, samples stored after the trigger sample; legal range 0..DEPTH-1.

Ports:
- clk  in  1  sole clock, rising edge.
- clr  in  1  synchronous active-high reset (decided: one clock, sync active-high reset).
- arm  in  1  one-cycle pulse; starts a capture.
- trig_en  in  1  enables the pc-match trigger; when 0, capture never triggers.
- trig_pc  in  WIDTH  trigger address compared against ch 0.
- sample_en  in  1  qualifies ch_data this cycle (e.g. CPU not stalled).
- ch_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- rd_valid  out  1  rd_data holds a captured entry.
- rd_ready  in  1  consumer accepts the entry.
- rd_data  out  NCH*WIDTH  current readout entry.
- rd_last  out  1  rd_data is the newest (final) entry.
- busy  out  1  state is ARMED or POST.
- done  out  1  state is DONE or READ.
- fill  out  $clog2(DEPTH)+1  number of valid entries, saturating at DEPTH.

Behaviour:
- States: IDLE, ARMED, POST, DONE, READ; 3-bit encoding.
- Reset (clr=1 at an edge), from any state including mid-capture or mid-readout:
  - state=IDLE, wr_ptr=0, rd_ptr=0, fill=0, post_cnt=0.
  - All outputs 0.
  - Buffer contents are don't-care and need not be cleared.
- IDLE:
  - arm -> ARMED, with wr_ptr=0 and fill=0.
  - sample_en is ignored.
- ARMED, on each cycle with sample_en=1:
  - Write ch_data at wr_ptr; wr_ptr increments mod DEPTH; fill increments, saturating at DEPTH (oldest entry overwritten on wrap).
  - If trig_en and ch0==trig_pc in the same cycle: the matching sample is written, post_cnt=POST, and the next state is POST, or DONE if POST==0.
- POST, on each cycle with sample_en=1:
  - Write as in ARMED; post_cnt decrements.
  - When the write made with post_cnt==1 completes -> DONE.
  - Further pc matches are ignored.
- DONE:
  - Samples are ignored and the buffer is frozen.
  - rd_ptr = (wr_ptr - fill) mod DEPTH, i.e. the oldest entry.
  - Next cycle -> READ.
- READ:
  - rd_valid=1; rd_data = mem[rd_ptr] combinationally; rd_last = (entries remaining == 1).
  - Transfer occurs when rd_valid && rd_ready; rd_ptr then increments mod DEPTH.
  - A transfer with rd_last=1 -> IDLE; rd_valid drops the following cycle.
  - rd_data must hold stable while rd_valid && !rd_ready.
- arm outside IDLE:
  - Ignored in ARMED and POST.
  - In DONE or READ, abandons the readout and restarts as in IDLE.
- Simultaneous arm and clr: clr wins.
- Latency:
  - Trigger to DONE: exactly POST qualified samples after the trigger sample.
  - DONE to first rd_valid: 1 cycle.
  - Readout rate: 1 entry per cycle under continuous rd_ready.
- Width rules: pointers are $clog2(DEPTH) bits and wrap naturally. fill is one bit wider so the value DEPTH is representable.
- Trigger before wrap: if fewer than DEPTH samples were stored, the readout returns only fill entries, starting at index 0.

Decomposition:
- Package cpu_trace_pkg holds:
  - state enum (TR_IDLE, TR_ARMED, TR_POST, TR_DONE, TR_READ);
  - localparam helpers PTR_W = $clog2(DEPTH) and ENTRY_W = NCH*WIDTH.
- One sub-module is natural: trace_ram, a DEPTH x ENTRY_W register array with one synchronous write port and one asynchronous read port.
- The control FSM, pointers and counters stay in cpu_trace_buffer.

Test Plan:
- Basic trigger, defaults: arm; ch0 ramps 0,4,8,... every cycle; trig_pc=0x40.
  - Trigger at sample 16; DONE after 8 more samples.
  - Readout gives 16 entries: ch0 0x24..0x60, the last 16 written (sample 9 through sample 24).
  - rd_last on ch0=0x60.
- Early trigger: trig_pc=0x8 (sample 2), POST=8.
  - fill=11; readout ch0 = 0x0..0x28; wr_ptr not wrapped.
- Backpressure and gaps:
  - sample_en toggling 1/0: only qualified cycles are stored and counted.
  - During readout, rd_ready low for 3 cycles: rd_data stable, no entry skipped or duplicated.
- No trigger: trig_en=0, 100 samples.
  - State stays ARMED; fill saturates at 16; done=0.
  - arm pulses are ignored.
- Reset mid-operation: clr asserted in POST and, separately, in READ.
  - Next cycle all outputs 0 and state IDLE.
  - A fresh arm captures correctly.
- POST=0 variant: trigger at ch0=0x40.
  - DONE the cycle after the trigger sample; the last read entry is ch0=0x40 with rd_last=1.
